ecu_gpio_bank: RTL

Parametrised GPIO bank for the RISC-V ECU system. It replaces the separate per-function PIO instances (read, write, set) with a single Avalon-MM slave that serves NUM_PORTS ports of WIDTH bits each. Each port provides:
- synchronised inputs,
- atomic set/clear/toggle of outputs,
- per-bit rising/falling edge capture,
- a level interrupt.

It sits on the PULPino-side Avalon fabric, with its gpio pins exported to the system top level.

---
 rtl/ecu_gpio_pkg.sv | 21 ++
 rtl/ecu_gpio_port.sv | 102 ++++++++++
 rtl/ecu_gpio_bank.sv | 111 +++++++++++
 3 files changed

// File: rtl/ecu_gpio_pkg.sv
// Shared definitions for the ECU GPIO bank: register map within a port
// and the sizing helper for the post-reset warm-up counter.
package ecu_gpio_pkg;

    localparam int REG_BITS = 3;

    localparam logic [REG_BITS-1:0] REG_IN      = 3'd0;
    localparam logic [REG_BITS-1:0] REG_OUT     = 3'd1;
    localparam logic [REG_BITS-1:0] REG_SET     = 3'd2;
    localparam logic [REG_BITS-1:0] REG_CLR     = 3'd3;
    localparam logic [REG_BITS-1:0] REG_TGL     = 3'd4;
    localparam logic [REG_BITS-1:0] REG_RISE_EN = 3'd5;
    localparam logic [REG_BITS-1:0] REG_FALL_EN = 3'd6;
    localparam logic [REG_BITS-1:0] REG_EDGE    = 3'd7;

    // The counter must hold 0..sync_stages+1 inclusive.
    function automatic int warmup_cnt_width(input int sync_stages);
        return $clog2(sync_stages + 2);
    endfunction

endpackage

// File: rtl/ecu_gpio_port.sv
// One GPIO port: input synchroniser, edge detection and capture, and the
// OUT / RISE_EN / FALL_EN / EDGE registers with their write side effects.
module ecu_gpio_port
    import ecu_gpio_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                edge_en,
    input  logic                wr_en,
    input  logic [REG_BITS-1:0] reg_sel,
    input  logic [WIDTH-1:0]    wdata,
    input  logic [WIDTH-1:0]    pin,
    output logic [WIDTH-1:0]    rdata,
    output logic [WIDTH-1:0]    gpio_out,
    output logic                edge_any
);

    logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
    logic [WIDTH-1:0] prev_q;
    logic [WIDTH-1:0] out_q;
    logic [WIDTH-1:0] rise_en_q;
    logic [WIDTH-1:0] fall_en_q;
    logic [WIDTH-1:0] edge_q;

    logic [WIDTH-1:0] sync_val;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic [WIDTH-1:0] hit;
    logic [WIDTH-1:0] w1c_mask;
    logic [WIDTH-1:0] edge_next;

    assign sync_val = sync_q[SYNC_STAGES-1];
    assign rise     = sync_val & ~prev_q;
    assign fall     = ~sync_val & prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            prev_q <= '0;
        end else begin
            sync_q[0] <= pin;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            prev_q <= sync_val;
        end
    end

    // New edges are ORed in after the clear so a coincident edge survives W1C.
    always_comb begin
        hit       = '0;
        w1c_mask  = '0;
        if (edge_en) begin
            hit = (rise & rise_en_q) | (fall & fall_en_q);
        end
        if (wr_en && (reg_sel == REG_EDGE)) begin
            w1c_mask = wdata;
        end
        edge_next = (edge_q & ~w1c_mask) | hit;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q     <= '0;
            rise_en_q <= '0;
            fall_en_q <= '0;
            edge_q    <= '0;
        end else begin
            edge_q <= edge_next;
            if (wr_en) begin
                case (reg_sel)
                    REG_OUT:     out_q     <= wdata;
                    REG_SET:     out_q     <= out_q | wdata;
                    REG_CLR:     out_q     <= out_q & ~wdata;
                    REG_TGL:     out_q     <= out_q ^ wdata;
                    REG_RISE_EN: rise_en_q <= wdata;
                    REG_FALL_EN: fall_en_q <= wdata;
                    default:     ;
                endcase
            end
        end
    end

    always_comb begin
        rdata = '0;
        case (reg_sel)
            REG_IN:      rdata = sync_val;
            REG_OUT:     rdata = out_q;
            REG_RISE_EN: rdata = rise_en_q;
            REG_FALL_EN: rdata = fall_en_q;
            REG_EDGE:    rdata = edge_q;
            default:     rdata = '0;
        endcase
    end

    assign gpio_out = out_q;
    assign edge_any = |edge_q;

endmodule

// File: rtl/ecu_gpio_bank.sv
// Avalon-MM GPIO bank serving NUM_PORTS ports: address decode, registered
// read path, shared post-reset warm-up counter and the level interrupt.
module ecu_gpio_bank
    import ecu_gpio_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int NUM_PORTS   = 3,
    parameter int SYNC_STAGES = 2
) (
    input  logic                                  clk_clk,
    input  logic                                  reset_reset_n,
    input  logic [$clog2(NUM_PORTS)+REG_BITS-1:0] avs_address,
    input  logic                                  avs_read,
    input  logic                                  avs_write,
    input  logic [31:0]                           avs_writedata,
    output logic [31:0]                           avs_readdata,
    output logic                                  avs_readdatavalid,
    input  logic [NUM_PORTS*WIDTH-1:0]            gpio_in,
    output logic [NUM_PORTS*WIDTH-1:0]            gpio_out,
    output logic                                  irq
);

    // Handshake: there is no waitrequest, so avs_read / avs_write are accepted
    // on every cycle they are high; each accepted read produces exactly one
    // avs_readdatavalid pulse on the following cycle, carrying that read's data.

    localparam int PORT_BITS = $clog2(NUM_PORTS);
    localparam int PIW       = (PORT_BITS > 0) ? PORT_BITS : 1;
    localparam int ADDR_W    = PORT_BITS + REG_BITS;
    localparam int CNT_W     = warmup_cnt_width(SYNC_STAGES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SYNC_STAGES + 1);

    logic [PIW-1:0]      port_idx;
    logic                port_valid;
    logic [REG_BITS-1:0] reg_sel;
    logic [CNT_W-1:0]    warm_cnt;
    logic                edge_en;

    logic [WIDTH-1:0]     port_rdata [NUM_PORTS];
    logic [NUM_PORTS-1:0] port_edge_any;
    logic [WIDTH-1:0]     rd_sel;
    logic [31:0]          rd_word;

    assign reg_sel = avs_address[REG_BITS-1:0];

    generate
        if (PORT_BITS > 0) begin : g_idx
            assign port_idx   = avs_address[ADDR_W-1:REG_BITS];
            assign port_valid = (32'(port_idx) < NUM_PORTS);
        end else begin : g_idx_single
            assign port_idx   = '0;
            assign port_valid = 1'b1;
        end
    endgenerate

    // Pins already high at reset would otherwise look like rising edges
    // while the synchroniser and prev flops fill.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            warm_cnt <= '0;
        end else if (warm_cnt != CNT_MAX) begin
            warm_cnt <= warm_cnt + CNT_W'(1);
        end
    end

    assign edge_en = (warm_cnt == CNT_MAX);

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
        ecu_gpio_port #(
            .WIDTH       (WIDTH),
            .SYNC_STAGES (SYNC_STAGES)
        ) u_port (
            .clk      (clk_clk),
            .rst_n    (reset_reset_n),
            .edge_en  (edge_en),
            .wr_en    (avs_write && port_valid && (port_idx == PIW'(p))),
            .reg_sel  (reg_sel),
            .wdata    (avs_writedata[WIDTH-1:0]),
            .pin      (gpio_in[p*WIDTH +: WIDTH]),
            .rdata    (port_rdata[p]),
            .gpio_out (gpio_out[p*WIDTH +: WIDTH]),
            .edge_any (port_edge_any[p])
        );
    end

    always_comb begin
        rd_sel = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (port_valid && (port_idx == PIW'(p))) begin
                rd_sel = port_rdata[p];
            end
        end
        rd_word              = '0;
        rd_word[WIDTH-1:0]   = rd_sel;
    end

    // Read data is sampled before this edge's writes land, so a same-cycle
    // read of a written register returns the old value.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            avs_readdata      <= '0;
            avs_readdatavalid <= 1'b0;
            irq               <= 1'b0;
        end else begin
            avs_readdatavalid <= avs_read;
            avs_readdata      <= avs_read ? rd_word : 32'h0;
            irq               <= |port_edge_any;
        end
    end

endmodule
